// File: rtl/faultify_pkg.sv
// Shared types, default sizes and the saturating-increment helper for the Faultify result checker.
package faultify_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } stateT;

    localparam int unsigned RESULT_WIDTH_DEF = 41;
    localparam int unsigned READY_BIT_DEF    = 32;
    localparam int unsigned CNT_WIDTH_DEF    = 32;

    // Width-generic: callers zero-extend into 64 bits and truncate the result back.
    function automatic logic [63:0] satInc(input logic [63:0] value, input int unsigned width);
        logic [63:0] maxVal;
        maxVal = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value == maxVal) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/faultify_sat_counter.sv
// Parameterized-width counter with synchronous clear and an increment that saturates at all-ones.
module faultify_sat_counter
    import faultify_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cntQ, cntD;

    always_comb begin
        cntD = cntQ;
        if (clr_i) begin
            cntD = '0;
        end else if (inc_i) begin
            cntD = WIDTH'(satInc(64'(cntQ), WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign cnt_o = cntQ;

endmodule

// File: rtl/faultify_result_checker.sv
// Scores faulty-vs-golden CUT result vectors over a bounded campaign of N samples.
// Optional per-bit error counters are built when FAULTIFY_PER_BIT_CNT_EN is defined.
module faultify_result_checker
    import faultify_pkg::*;
#(
    parameter int unsigned RESULT_WIDTH  = RESULT_WIDTH_DEF,
    parameter int unsigned READY_BIT     = READY_BIT_DEF,
    parameter int unsigned CNT_WIDTH     = CNT_WIDTH_DEF,
    parameter int unsigned BIT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [CNT_WIDTH-1:0]     num_samples_i,
    input  logic [RESULT_WIDTH-1:0]  compare_mask_i,
    input  logic [RESULT_WIDTH-1:0]  golden_i,
    input  logic [RESULT_WIDTH-1:0]  faulty_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [CNT_WIDTH-1:0]     sample_cnt_o,
    output logic [CNT_WIDTH-1:0]     error_cnt_o,
    output logic [RESULT_WIDTH-1:0]  bit_err_acc_o,
    output logic [RESULT_WIDTH-1:0]  first_err_vec_o,
    output logic [CNT_WIDTH-1:0]     first_err_idx_o,
    input  logic [5:0]               bit_sel_i,
    output logic [BIT_CNT_WIDTH-1:0] bit_cnt_o
);

    stateT                   stateQ, stateD;
    logic [CNT_WIDTH-1:0]    numSamplesQ, numSamplesD;
    logic [RESULT_WIDTH-1:0] maskQ, maskD;
    logic [RESULT_WIDTH-1:0] s1GoldenQ, s1FaultyQ;
    logic                    s1ValidQ, s1ValidD;
    logic [RESULT_WIDTH-1:0] bitErrAccQ, bitErrAccD;
    logic [RESULT_WIDTH-1:0] firstErrVecQ, firstErrVecD;
    logic [CNT_WIDTH-1:0]    firstErrIdxQ, firstErrIdxD;

    logic                    startAccept;
    logic                    scoreValid;
    logic                    mism;
    logic [RESULT_WIDTH-1:0] diff;
    logic [CNT_WIDTH-1:0]    sampleCnt, errorCnt, sampleCntInc;

    assign diff         = (s1GoldenQ ^ s1FaultyQ) & maskQ;
    assign mism         = |diff;
    assign scoreValid   = s1ValidQ && (stateQ == StRun);
    assign startAccept  = start_i && (stateQ != StRun);
    assign sampleCntInc = CNT_WIDTH'(satInc(64'(sampleCnt), CNT_WIDTH));

    always_comb begin
        stateD       = stateQ;
        numSamplesD  = numSamplesQ;
        maskD        = maskQ;
        s1ValidD     = 1'b0;
        bitErrAccD   = bitErrAccQ;
        firstErrVecD = firstErrVecQ;
        firstErrIdxD = firstErrIdxQ;
        unique case (stateQ)
            StIdle, StDone: begin
                if (start_i) begin
                    numSamplesD  = num_samples_i;
                    maskD        = compare_mask_i;
                    bitErrAccD   = '0;
                    firstErrVecD = '0;
                    firstErrIdxD = '0;
                    stateD       = (num_samples_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                // Only the golden ready bit qualifies a sample.
                s1ValidD = golden_i[READY_BIT];
                if (scoreValid) begin
                    if (mism) begin
                        bitErrAccD = bitErrAccQ | diff;
                        if (errorCnt == '0) begin
                            firstErrVecD = diff;
                            firstErrIdxD = sampleCnt;
                        end
                    end
                    // Samples still in S1 when the campaign ends are dropped.
                    if (sampleCntInc == numSamplesQ) begin
                        stateD   = StDone;
                        s1ValidD = 1'b0;
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ       <= StIdle;
            numSamplesQ  <= '0;
            maskQ        <= '0;
            s1GoldenQ    <= '0;
            s1FaultyQ    <= '0;
            s1ValidQ     <= 1'b0;
            bitErrAccQ   <= '0;
            firstErrVecQ <= '0;
            firstErrIdxQ <= '0;
        end else begin
            stateQ       <= stateD;
            numSamplesQ  <= numSamplesD;
            maskQ        <= maskD;
            s1GoldenQ    <= golden_i;
            s1FaultyQ    <= faulty_i;
            s1ValidQ     <= s1ValidD;
            bitErrAccQ   <= bitErrAccD;
            firstErrVecQ <= firstErrVecD;
            firstErrIdxQ <= firstErrIdxD;
        end
    end

    faultify_sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) uSampleCnt (
        .clk  (clk),
        .rst  (rst),
        .clr_i(startAccept),
        .inc_i(scoreValid),
        .cnt_o(sampleCnt)
    );

    faultify_sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) uErrorCnt (
        .clk  (clk),
        .rst  (rst),
        .clr_i(startAccept),
        .inc_i(scoreValid && mism),
        .cnt_o(errorCnt)
    );

`ifdef FAULTIFY_PER_BIT_CNT_EN
    logic [BIT_CNT_WIDTH-1:0] perBitCnt [RESULT_WIDTH];
    logic [BIT_CNT_WIDTH-1:0] bitCntQ;

    for (genvar k = 0; k < RESULT_WIDTH; k++) begin : gBitCnt
        faultify_sat_counter #(
            .WIDTH(BIT_CNT_WIDTH)
        ) uBitCnt (
            .clk  (clk),
            .rst  (rst),
            .clr_i(startAccept),
            .inc_i(scoreValid && diff[k]),
            .cnt_o(perBitCnt[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitCntQ <= '0;
        end else if (32'(bit_sel_i) < RESULT_WIDTH) begin
            bitCntQ <= perBitCnt[bit_sel_i];
        end else begin
            bitCntQ <= '0;
        end
    end

    assign bit_cnt_o = bitCntQ;
`else
    logic unusedBitSel;
    assign unusedBitSel = ^bit_sel_i;
    assign bit_cnt_o    = '0;
`endif

    assign busy_o          = (stateQ == StRun);
    assign done_o          = (stateQ == StDone);
    assign sample_cnt_o    = sampleCnt;
    assign error_cnt_o     = errorCnt;
    assign bit_err_acc_o   = bitErrAccQ;
    assign first_err_vec_o = firstErrVecQ;
    assign first_err_idx_o = firstErrIdxQ;

endmodule

// File: tb/tb_faultify_result_checker.sv
// Directed self-checking bench for faultify_result_checker (default parameters).
module tb_faultify_result_checker;

    localparam logic [40:0] READY = 41'h1_0000_0000;
    localparam logic [40:0] ALL   = '1;
    localparam logic [40:0] G     = READY | 41'h100;
    localparam logic [40:0] B5    = 41'h20;
    localparam logic [40:0] B7    = 41'h80;
    localparam logic [40:0] B9    = 41'h200;
    localparam logic [40:0] B31   = 41'h0_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] num_samples_i;
    logic [40:0] compare_mask_i;
    logic [40:0] golden_i;
    logic [40:0] faulty_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] sample_cnt_o;
    logic [31:0] error_cnt_o;
    logic [40:0] bit_err_acc_o;
    logic [40:0] first_err_vec_o;
    logic [31:0] first_err_idx_o;
    logic [5:0]  bit_sel_i;
    logic [15:0] bit_cnt_o;

    int checks   = 0;
    int failures = 0;

    faultify_result_checker dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .num_samples_i  (num_samples_i),
        .compare_mask_i (compare_mask_i),
        .golden_i       (golden_i),
        .faulty_i       (faulty_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .sample_cnt_o   (sample_cnt_o),
        .error_cnt_o    (error_cnt_o),
        .bit_err_acc_o  (bit_err_acc_o),
        .first_err_vec_o(first_err_vec_o),
        .first_err_idx_o(first_err_idx_o),
        .bit_sel_i      (bit_sel_i),
        .bit_cnt_o      (bit_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic present(input logic [40:0] g, input logic [40:0] f);
        golden_i = g;
        faulty_i = f;
        @(negedge clk);
    endtask

    // A mismatching ready sample rides along with start and must be ignored.
    task automatic startCampaign(input logic [31:0] n, input logic [40:0] mask);
        start_i        = 1'b1;
        num_samples_i  = n;
        compare_mask_i = mask;
        golden_i       = READY;
        faulty_i       = READY ^ 41'h1;
        @(negedge clk);
        start_i  = 1'b0;
        golden_i = '0;
        faulty_i = '0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".busy"}, 64'(busy_o), 64'd0);
        check({tag, ".done"}, 64'(done_o), 64'd0);
        check({tag, ".sample"}, 64'(sample_cnt_o), 64'd0);
        check({tag, ".error"}, 64'(error_cnt_o), 64'd0);
        check({tag, ".acc"}, 64'(bit_err_acc_o), 64'd0);
        check({tag, ".vec"}, 64'(first_err_vec_o), 64'd0);
        check({tag, ".idx"}, 64'(first_err_idx_o), 64'd0);
        check({tag, ".bitcnt"}, 64'(bit_cnt_o), 64'd0);
    endtask

    initial begin
        rst            = 1'b1;
        start_i        = 1'b0;
        num_samples_i  = '0;
        compare_mask_i = '0;
        golden_i       = '0;
        faulty_i       = '0;
        bit_sel_i      = '0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        // N=4, matching samples
        startCampaign(32'd4, ALL);
        check("t1.busy", 64'(busy_o), 64'd1);
        for (int i = 0; i < 4; i++) present(READY | 41'(i + 1), READY | 41'(i + 1));
        present(41'd0, 41'd0);
        check("t1.latency_cnt", 64'(sample_cnt_o), 64'd4);
        check("t1.done", 64'(done_o), 64'd1);
        check("t1.busy_off", 64'(busy_o), 64'd0);
        check("t1.error", 64'(error_cnt_o), 64'd0);
        check("t1.acc", 64'(bit_err_acc_o), 64'd0);
        present(READY, READY ^ 41'h1);
        present(READY, READY ^ 41'h1);
        present(41'd0, 41'd0);
        check("t1.frozen_cnt", 64'(sample_cnt_o), 64'd4);
        check("t1.frozen_err", 64'(error_cnt_o), 64'd0);

        // N=3, errors on samples 1 and 2
        startCampaign(32'd3, ALL);
        check("t2.cleared", 64'(sample_cnt_o), 64'd0);
        present(G, G);
        present(G, G ^ B5);
        present(G, G ^ B31);
        check("t2.mid_cnt", 64'(sample_cnt_o), 64'd2);
        check("t2.mid_done", 64'(done_o), 64'd0);
        present(41'd0, 41'd0);
        check("t2.done", 64'(done_o), 64'd1);
        check("t2.sample", 64'(sample_cnt_o), 64'd3);
        check("t2.error", 64'(error_cnt_o), 64'd2);
        check("t2.acc", 64'(bit_err_acc_o), 64'h0_8000_0020);
        check("t2.vec", 64'(first_err_vec_o), 64'h20);
        check("t2.idx", 64'(first_err_idx_o), 64'd1);

        // Bit 5 masked off; faulty-only ready is not scored
        startCampaign(32'd2, ALL & ~B5);
        present(G, G ^ B5);
        present(41'd0, READY);
        present(G, G ^ B5);
        check("t3.mid_cnt", 64'(sample_cnt_o), 64'd1);
        present(41'd0, 41'd0);
        check("t3.done", 64'(done_o), 64'd1);
        check("t3.sample", 64'(sample_cnt_o), 64'd2);
        check("t3.error", 64'(error_cnt_o), 64'd0);
        check("t3.acc", 64'(bit_err_acc_o), 64'd0);

        // N=0 completes immediately
        startCampaign(32'd0, ALL);
        check("t4.done", 64'(done_o), 64'd1);
        check("t4.busy", 64'(busy_o), 64'd0);
        check("t4.sample", 64'(sample_cnt_o), 64'd0);
        check("t4.error", 64'(error_cnt_o), 64'd0);

        // N=10 full-rate, second start ignored, reset aborts
        startCampaign(32'd10, ALL);
        check("t5.busy", 64'(busy_o), 64'd1);
        check("t5.done", 64'(done_o), 64'd0);
        present(G, G);
        present(G, G);
        present(G, G ^ B9);
        start_i       = 1'b1;
        num_samples_i = 32'd2;
        present(G, G);
        start_i = 1'b0;
        present(G, G);
        present(G, G);
        check("t5.restart_ignored", 64'(sample_cnt_o), 64'd5);
        check("t5.still_busy", 64'(busy_o), 64'd1);
        check("t5.error", 64'(error_cnt_o), 64'd1);
        check("t5.idx", 64'(first_err_idx_o), 64'd2);
        rst = 1'b1;
        present(41'd0, 41'd0);
        checkAllZero("t5.rst");
        rst = 1'b0;
        @(negedge clk);

        // Bit 7 differs in 3 of 5 samples
        startCampaign(32'd5, ALL);
        present(G, G ^ B7);
        present(G, G ^ B9);
        present(G, G ^ B7);
        present(G, G);
        present(G, G ^ B7);
        present(41'd0, 41'd0);
        check("t6.done", 64'(done_o), 64'd1);
        check("t6.error", 64'(error_cnt_o), 64'd4);
        check("t6.acc", 64'(bit_err_acc_o), 64'h280);
        check("t6.vec", 64'(first_err_vec_o), 64'h80);
        check("t6.idx", 64'(first_err_idx_o), 64'd0);
`ifdef FAULTIFY_PER_BIT_CNT_EN
        bit_sel_i = 6'd7;
        @(negedge clk);
        check("t6.bitcnt7", 64'(bit_cnt_o), 64'd3);
        bit_sel_i = 6'd50;
        @(negedge clk);
        check("t6.bitcnt50", 64'(bit_cnt_o), 64'd0);
        bit_sel_i = 6'd9;
        @(negedge clk);
        check("t6.bitcnt9", 64'(bit_cnt_o), 64'd1);
`else
        bit_sel_i = 6'd7;
        @(negedge clk);
        check("t6.bitcnt_tied", 64'(bit_cnt_o), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/faultify_result_checker.md
Name: faultify_result_checker

Overview:
- Downstream consumer of the circuit-under-test result vectors. Compares the faulty CUT instance's resultVector against a golden (fault-free) instance.
- A result is scored each time the golden instance signals ready. The block counts scored samples and mismatching samples, accumulates which output bits ever differed, and captures the first failing difference.
- It runs a bounded campaign of N samples under start/done control and is read by the AXI wrapper's register file.

Parameters:
- RESULT_WIDTH, 41, width of each result vector.
- READY_BIT, 32, index of the ready flag inside the result vector.
- CNT_WIDTH, 32, width of the sample and error counters.
- BIT_CNT_WIDTH, 16, width of each per-bit counter (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  single-cycle campaign start pulse.
- num_samples_i  in  CNT_WIDTH  samples per campaign; sampled on start_i.
- compare_mask_i  in  RESULT_WIDTH  1 = bit participates in comparison; sampled on start_i.
- golden_i  in  RESULT_WIDTH  result vector from the golden CUT.
- faulty_i  in  RESULT_WIDTH  result vector from the fault-injected CUT.
- busy_o  out  1  campaign running.
- done_o  out  1  campaign complete; held until the next start.
- sample_cnt_o  out  CNT_WIDTH  samples scored.
- error_cnt_o  out  CNT_WIDTH  samples with a masked mismatch.
- bit_err_acc_o  out  RESULT_WIDTH  sticky OR of all masked difference vectors.
- first_err_vec_o  out  RESULT_WIDTH  masked difference vector of the first failing sample.
- first_err_idx_o  out  CNT_WIDTH  sample index (0-based) of the first failure.
- bit_sel_i  in  6  per-bit counter select (optional feature only).
- bit_cnt_o  out  BIT_CNT_WIDTH  selected per-bit counter (optional feature only).

Behaviour:
- One clock; reset is synchronous and active-high (ports clk and rst).
- Reset:
  - All outputs are 0, state is IDLE, and pipeline valids are cleared.
- States:
  - IDLE: waits for start_i. On start_i, latch num_samples_i and compare_mask_i, clear all counters and capture registers, clear pipeline valids. If the latched N = 0, go to DONE; otherwise go to RUN.
  - RUN: busy_o = 1. start_i is ignored.
  - DONE: done_o = 1 and busy_o = 0. Outputs are frozen. start_i behaves exactly as in IDLE.
- Pipeline (2 stages):
  - S1: in RUN, register golden_i and faulty_i. s1_valid = golden_i[READY_BIT]. The faulty ready bit does not qualify the sample.
  - S2: diff = (g ^ f) & mask, and mism = |diff. A set faulty ready bit with a cleared golden ready bit is not scored.
  - A sample presented in cycle t is reflected in the counters in cycle t+2.
  - Samples presented in the same cycle as start_i are ignored.
- Scoring on a valid S2 sample:
  - sample_cnt increments.
  - If mism: error_cnt increments and bit_err_acc |= diff.
  - If mism and this is the first error of the campaign: first_err_vec = diff and first_err_idx = the pre-increment sample_cnt.
- Completion:
  - When the post-increment sample_cnt equals N, move RUN -> DONE in the same cycle the count updates.
  - Samples in S1 at that moment are discarded.
- Counters saturate at all-ones and never wrap. A saturated error_cnt does not block the sample_cnt termination check.
- Back-to-back ready pulses (every cycle) must be scored at full rate.
- rst asserted mid-campaign aborts the campaign and returns everything to reset values on the next edge.

Optional Feature:
- Macro: FAULTIFY_PER_BIT_CNT_EN.
- Defined:
  - RESULT_WIDTH saturating counters of BIT_CNT_WIDTH bits. Counter k increments on each scored sample with diff[k] = 1.
  - All counters are cleared on start/reset.
  - bit_cnt_o is the registered value of counter[bit_sel_i], 1-cycle latency. bit_sel_i >= RESULT_WIDTH returns 0.
- Undefined:
  - No counters are instantiated, bit_cnt_o is tied to 0, and bit_sel_i is unused.

Decomposition:
- Shared package faultify_pkg:
  - The state enum (IDLE, RUN, DONE).
  - Default constants RESULT_WIDTH_DEF = 41, READY_BIT_DEF = 32, CNT_WIDTH_DEF = 32.
  - A saturating-increment function.
- One sub-module: faultify_sat_counter, a parameterized width counter with clr, inc, and saturation. It is used for sample_cnt, error_cnt and the per-bit counters.

Test Plan:
- N=4, mask all-ones, golden = faulty = 0x1_0000_0000 | data on 4 ready cycles -> done_o after the 4th sample+2 cycles, sample_cnt=4, error_cnt=0, bit_err_acc=0.
- N=3, faulty differs in bit 5 on sample 1 and bit 31 on sample 2 -> error_cnt=2, bit_err_acc=0x0_8000_0020, first_err_vec=0x20, first_err_idx=1.
- Mask bit 5 cleared and faulty differs only in bit 5 -> error_cnt=0.
- N=0 start -> done_o=1 one cycle later, all counts 0.
- N=10, ready every cycle, rst asserted after 5 samples -> all outputs 0, state IDLE.
- Second start while in RUN ignored. start in DONE clears counters and restarts.
- With FAULTIFY_PER_BIT_CNT_EN: bit 7 differs in 3 of 5 samples, bit_sel_i=7 -> bit_cnt_o=3 next cycle. bit_sel_i=50 -> bit_cnt_o=0.
